hitmark_sprite_reader: RTL and testbench

// - Read-side client of the hitmark bitmap RAM: turns VGA pixel coordinates into RAM read addresses.
// - Aligns the RAM's 1-cycle registered read and emits the hitmark pixel colour plus an on/opaque flag to the pixel mux.
// - Owns the hitmark lifetime: a hit pulse arms a marker at the hit position for a fixed number of frames.
// - Position and arming change only at frame boundaries, so the marker never tears.

---
 rtl/hitmark_sprite_reader_if.sv | 28 ++
 rtl/hitmark_sprite_reader.sv | 131 +++++++++++++
 tb/tb_hitmark_sprite_reader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hitmark_sprite_reader_if.sv
// Bundle between the hitmark sprite reader and its neighbours: VGA coordinates, hit events,
// hitmark RAM read port and the pixel-mux outputs.
interface hitmark_sprite_reader_if #(
    parameter int unsigned SPRITE_LOG2 = 5,
    parameter int unsigned DATA_WIDTH  = 4
);
    logic [9:0]               pixel_x;
    logic [9:0]               pixel_y;
    logic                     frame_tick;
    logic                     hit;
    logic [9:0]               hit_x;
    logic [9:0]               hit_y;
    logic [2*SPRITE_LOG2-1:0] addr_r;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic                     hitmark_on;
    logic [DATA_WIDTH-1:0]    hitmark_rgb;
    logic                     active;

    modport master (
        output pixel_x, pixel_y, frame_tick, hit, hit_x, hit_y, ram_dout,
        input  addr_r, hitmark_on, hitmark_rgb, active
    );

    modport slave (
        input  pixel_x, pixel_y, frame_tick, hit, hit_x, hit_y, ram_dout,
        output addr_r, hitmark_on, hitmark_rgb, active
    );
endinterface

// File: rtl/hitmark_sprite_reader.sv
// Hitmark sprite reader: arms a marker on a hit, updates it on frame boundaries and turns pixel
// coordinates into hitmark RAM addresses, aligning the registered RAM read to the pixel mux.
module hitmark_sprite_reader #(
    parameter int unsigned SPRITE_LOG2  = 5,
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned H_PIX        = 640,
    parameter int unsigned V_PIX        = 480,
    parameter int unsigned TRANSP       = 0,
    parameter int unsigned LIFE_FRAMES  = 30,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input logic clk,
    input logic reset_n,
    hitmark_sprite_reader_if.slave bus
);

    localparam int unsigned SPR = 2 ** SPRITE_LOG2;
    localparam int unsigned AW  = 2 * SPRITE_LOG2;

    localparam logic signed [10:0] HALF_S = 11'(SPR / 2);
    localparam logic [9:0]         X_MAX  = 10'(H_PIX - SPR);
    localparam logic [9:0]         Y_MAX  = 10'(V_PIX - SPR);
    localparam logic [10:0]        SPR_W  = 11'(SPR);
    localparam logic [7:0]         LIFE   = 8'(LIFE_FRAMES);
    localparam logic [7:0]         BLINK  = 8'(BLINK_FRAMES);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e    state_q, state_d;
    logic      pending_q, pending_d;
    logic [7:0] life_q, life_d;
    logic [9:0] lat_x_q, lat_x_d, lat_y_q, lat_y_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic      inbox_d1_q, inbox_d2_q;

    logic      vis, inbox, in_x, in_y;
    logic [SPRITE_LOG2-1:0] dx, dy;

    // Centre the sprite on the hit point, keeping the whole box on screen.
    function automatic logic [9:0] clamp_pos(input logic [9:0] c, input logic [9:0] hi);
        logic signed [10:0] d;
        d = $signed({1'b0, c}) - HALF_S;
        if (d < 0) begin
            return '0;
        end else if (d[9:0] > hi) begin
            return hi;
        end else begin
            return d[9:0];
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        life_d    = life_q;
        lat_x_d   = lat_x_q;
        lat_y_d   = lat_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;

        if (bus.frame_tick) begin
            if (pending_q) begin
                state_d   = StShow;
                pos_x_d   = lat_x_q;
                pos_y_d   = lat_y_q;
                life_d    = LIFE;
                pending_d = 1'b0;
            end else if (state_q == StShow) begin
                if (life_q == 8'd1) begin
                    state_d = StIdle;
                    life_d  = '0;
                end else begin
                    life_d = life_q - 8'd1;
                end
            end
        end

        // A hit on the tick edge lands after the tick consumed the old pending flag.
        if (bus.hit) begin
            pending_d = 1'b1;
            lat_x_d   = clamp_pos(bus.hit_x, X_MAX);
            lat_y_d   = clamp_pos(bus.hit_y, Y_MAX);
        end
    end

    always_comb begin
        // Tail blink: hidden whenever life[1] is set, giving 2 frames on / 2 off.
        vis   = (state_q == StShow) && !((life_q <= BLINK) && life_q[1]);
        in_x  = (bus.pixel_x >= pos_x_q) && ({1'b0, bus.pixel_x} < ({1'b0, pos_x_q} + SPR_W));
        in_y  = (bus.pixel_y >= pos_y_q) && ({1'b0, bus.pixel_y} < ({1'b0, pos_y_q} + SPR_W));
        inbox = vis && in_x && in_y;
        dx    = bus.pixel_x[SPRITE_LOG2-1:0] - pos_x_q[SPRITE_LOG2-1:0];
        dy    = bus.pixel_y[SPRITE_LOG2-1:0] - pos_y_q[SPRITE_LOG2-1:0];
        addr_d = inbox ? {dy, dx} : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            life_q     <= '0;
            lat_x_q    <= '0;
            lat_y_q    <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            addr_q     <= '0;
            inbox_d1_q <= 1'b0;
            inbox_d2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            life_q     <= life_d;
            lat_x_q    <= lat_x_d;
            lat_y_q    <= lat_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            addr_q     <= addr_d;
            inbox_d1_q <= inbox;
            inbox_d2_q <= inbox_d1_q;
        end
    end

    always_comb begin
        bus.addr_r      = addr_q;
        bus.active      = (state_q == StShow);
        bus.hitmark_on  = inbox_d2_q && (bus.ram_dout != DATA_WIDTH'(TRANSP));
        bus.hitmark_rgb = bus.hitmark_on ? bus.ram_dout : '0;
    end

endmodule

// File: tb/tb_hitmark_sprite_reader.sv
// Directed bench for hitmark_sprite_reader: vector table for the pixel pipeline plus sequences
// for reset, clamping, lifetime/blink, coincident hits and retriggering.
module tb_hitmark_sprite_reader;

    logic clk = 1'b0;
    logic reset_n;
    logic [3:0] ram_word;
    int n_cmp = 0;
    int n_fail = 0;

    hitmark_sprite_reader_if #(.SPRITE_LOG2(5), .DATA_WIDTH(4)) bus ();

    hitmark_sprite_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Registered-read RAM stand-in: one cycle from addr_r to ram_dout.
    always @(posedge clk) bus.ram_dout <= ram_word;

    typedef struct {
        int px;
        int py;
        int addr;
        int on;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_hit(input int x, input int y);
        bus.hit   = 1'b1;
        bus.hit_x = 10'(x);
        bus.hit_y = 10'(y);
        step();
        bus.hit   = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    // Pixel in, addr_r one clk later, on/rgb two clk later.
    task automatic apply_pix(input string nm, input int px, input int py,
                             input int exp_addr, input int exp_on, input int exp_rgb);
        bus.pixel_x = 10'(px);
        bus.pixel_y = 10'(py);
        step();
        chk({nm, " addr_r"}, int'(bus.addr_r), exp_addr);
        step();
        chk({nm, " hitmark_on"}, int'(bus.hitmark_on), exp_on);
        chk({nm, " hitmark_rgb"}, int'(bus.hitmark_rgb), exp_rgb);
    endtask

    initial begin
        int life;
        int exp_on;

        // Marker at (304,224), RAM returns 9.
        tbl[0] = '{px: 305, py: 226, addr: 65,   on: 1};
        tbl[1] = '{px: 304, py: 224, addr: 0,    on: 1};
        tbl[2] = '{px: 335, py: 255, addr: 1023, on: 1};
        tbl[3] = '{px: 336, py: 230, addr: 0,    on: 0};
        tbl[4] = '{px: 303, py: 230, addr: 0,    on: 0};
        tbl[5] = '{px: 310, py: 256, addr: 0,    on: 0};
        tbl[6] = '{px: 320, py: 240, addr: 528,  on: 1};

        reset_n        = 1'b0;
        ram_word       = 4'h9;
        bus.pixel_x    = '0;
        bus.pixel_y    = '0;
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b1;
        bus.hit_x      = 10'd320;
        bus.hit_y      = 10'd240;

        // Reset held 3 clk with hit asserted: nothing may be left pending.
        repeat (3) step();
        reset_n = 1'b1;
        bus.hit = 1'b0;
        chk("reset active", int'(bus.active), 0);
        chk("reset hitmark_on", int'(bus.hitmark_on), 0);
        chk("reset addr_r", int'(bus.addr_r), 0);
        pulse_tick();
        chk("reset pending cleared", int'(bus.active), 0);

        // Hit in IDLE without a tick stays invisible.
        pulse_hit(320, 240);
        apply_pix("idle hit no tick", 305, 226, 0, 0, 0);
        chk("idle hit no tick active", int'(bus.active), 0);

        pulse_tick();
        chk("arm active", int'(bus.active), 1);
        for (int i = 0; i < 7; i++) begin
            apply_pix($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].addr, tbl[i].on,
                      tbl[i].on ? 9 : 0);
        end

        // Clamp: (5,470) -> (0,448), retriggered from SHOW.
        pulse_hit(5, 470);
        pulse_tick();
        apply_pix("clamp col 32", 32, 448, 0, 0, 0);
        apply_pix("clamp corner", 31, 479, 1023, 1, 9);
        apply_pix("clamp origin", 0, 448, 0, 1, 9);

        ram_word = 4'h0;
        apply_pix("transparent", 10, 460, 394, 0, 0);
        ram_word = 4'h9;
        apply_pix("opaque before reset", 10, 460, 394, 1, 9);

        reset_n = 1'b0;
        step();
        chk("mid reset hitmark_on", int'(bus.hitmark_on), 0);
        chk("mid reset addr_r", int'(bus.addr_r), 0);
        chk("mid reset active", int'(bus.active), 0);
        reset_n = 1'b1;
        step();
        step();
        chk("after reset hitmark_on", int'(bus.hitmark_on), 0);

        // Lifetime and blink with pixel held inside the box.
        pulse_hit(320, 240);
        pulse_tick();
        bus.pixel_x = 10'd310;
        bus.pixel_y = 10'd230;
        repeat (3) step();
        chk("life 30 on", int'(bus.hitmark_on), 1);
        for (int k = 1; k <= 30; k++) begin
            pulse_tick();
            repeat (3) step();
            life   = 30 - k;
            exp_on = (life > 0) && ((life > 8) || (((life >> 1) & 1) == 0)) ? 1 : 0;
            chk($sformatf("life %0d on", life), int'(bus.hitmark_on), exp_on);
            chk($sformatf("life %0d active", life), int'(bus.active), (k < 30) ? 1 : 0);
        end

        // Hit coincident with a tick in IDLE arms only at the next tick.
        bus.hit        = 1'b1;
        bus.hit_x      = 10'd100;
        bus.hit_y      = 10'd100;
        bus.frame_tick = 1'b1;
        step();
        bus.hit        = 1'b0;
        bus.frame_tick = 1'b0;
        chk("coincident still idle", int'(bus.active), 0);
        pulse_tick();
        chk("coincident next tick", int'(bus.active), 1);
        apply_pix("coincident pos", 85, 84, 1, 1, 9);

        // Retrigger: position moves only at the tick, life reloads to 30.
        repeat (3) pulse_tick();
        pulse_hit(200, 200);
        apply_pix("retrig old pos kept", 85, 84, 1, 1, 9);
        pulse_tick();
        apply_pix("retrig old pos gone", 85, 84, 0, 0, 0);
        apply_pix("retrig new pos", 185, 186, 65, 1, 9);
        repeat (29) pulse_tick();
        chk("retrig life 1 active", int'(bus.active), 1);
        pulse_tick();
        chk("retrig expired", int'(bus.active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
